// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM states, default device address and bit-counter sizing.
package i2c_pkg;

  localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h55;
  localparam int         BIT_CNT_W        = 4;
  localparam logic [BIT_CNT_W-1:0] BIT_LAST  = 4'd7;
  localparam logic [BIT_CNT_W-1:0] BYTE_DONE = 4'd8;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEV_ADDR,
    ST_ACK_ADDR,
    ST_REG_PTR,
    ST_ACK_PTR,
    ST_WR_BYTE,
    ST_ACK_WR,
    ST_RD_BYTE,
    ST_RD_ACK,
    ST_WAIT_STOP
  } i2c_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// Synchronises one open-drain bus line, rejects pulses shorter than FILT_LEN clocks and flags edges.
module i2c_line_filter #(
  parameter int FILT_LEN = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CNT_W = $clog2(FILT_LEN + 1);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q;
  logic             level_q;
  logic             rise_q;
  logic             fall_q;

  // Lines idle high, so the synchroniser and filter start at 1 to avoid a phantom edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      level_q <= 1'b1;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      sync_q <= {sync_q[0], line_i};
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      if (sync_q[1] == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_W'(FILT_LEN - 1)) begin
        level_q <= sync_q[1];
        cnt_q   <= '0;
        rise_q  <= sync_q[1];
        fall_q  <= ~sync_q[1];
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/i2c_target_regport.sv
// I2C target exposing a byte-wide register port: pointer write, burst writes and sequential reads.
module i2c_target_regport
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = DEV_ADDR_DEFAULT,
  parameter int         FILT_LEN = 3,
  parameter int         PTR_W    = 8
) (
  input  logic             CLOCK_IN,
  input  logic             RST_N,
  input  logic             SCL_IN,
  input  logic             SDA_IN,
  output logic             SDA_OE,
  output logic             WR_EN,
  output logic [PTR_W-1:0] WR_ADDR,
  output logic [7:0]       WR_DATA,
  output logic [PTR_W-1:0] RD_ADDR,
  input  logic [7:0]       RD_DATA,
  output logic             BUSY,
  output logic [7:0]       NACK_CNT
);

  logic scl_f, scl_rise, scl_fall;
  logic sda_f, sda_rise, sda_fall;

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
    .clk(CLOCK_IN), .rst_n(RST_N), .line_i(SCL_IN),
    .level_o(scl_f), .rise_o(scl_rise), .fall_o(scl_fall)
  );

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
    .clk(CLOCK_IN), .rst_n(RST_N), .line_i(SDA_IN),
    .level_o(sda_f), .rise_o(sda_rise), .fall_o(sda_fall)
  );

  i2c_state_e           state_q, state_d;
  logic                 sda_oe_q, sda_oe_d;
  logic                 busy_q, busy_d;
  logic                 wr_en_q, wr_en_d;
  logic [PTR_W-1:0]     wr_addr_q, wr_addr_d;
  logic [7:0]           wr_data_q, wr_data_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [7:0]           nack_q, nack_d;
  logic [7:0]           shift_q, shift_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;

  logic       start_det, stop_det, last_rx, ack_done, addr_hit;
  logic [7:0] byte_in;

  assign start_det = sda_fall & scl_f;
  assign stop_det  = sda_rise & scl_f;
  assign byte_in   = {shift_q[6:0], sda_f};
  assign last_rx   = scl_rise && (bit_cnt_q == BIT_LAST);
  assign addr_hit  = (byte_in[7:1] == DEV_ADDR);
  // An ACK slot drives SDA on its first scl_fall and ends on the second; sda_oe_q tells them apart.
  assign ack_done  = scl_fall && sda_oe_q;

  always_ff @(posedge CLOCK_IN or negedge RST_N) begin
    if (!RST_N) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (stop_det) begin
      state_d = ST_IDLE;
    end else if (start_det) begin
      state_d = ST_DEV_ADDR;
    end else begin
      case (state_q)
        ST_DEV_ADDR: if (last_rx) state_d = addr_hit ? ST_ACK_ADDR : ST_WAIT_STOP;
        // The address byte stays in shift_q during its ACK, so bit 0 is still the R/W flag.
        ST_ACK_ADDR: if (ack_done) state_d = shift_q[0] ? ST_RD_BYTE : ST_REG_PTR;
        ST_REG_PTR:  if (last_rx) state_d = ST_ACK_PTR;
        ST_ACK_PTR:  if (ack_done) state_d = ST_WR_BYTE;
        ST_WR_BYTE:  if (last_rx) state_d = ST_ACK_WR;
        ST_ACK_WR:   if (ack_done) state_d = ST_WR_BYTE;
        ST_RD_BYTE:  if (scl_fall && bit_cnt_q == BYTE_DONE) state_d = ST_RD_ACK;
        ST_RD_ACK: begin
          if (scl_rise && sda_f) state_d = ST_WAIT_STOP;
          else if (scl_fall)     state_d = ST_RD_BYTE;
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    sda_oe_d  = sda_oe_q;
    busy_d    = busy_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    ptr_d     = ptr_q;
    nack_d    = nack_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    if (stop_det || start_det) begin
      sda_oe_d  = 1'b0;
      busy_d    = start_det;
      bit_cnt_d = '0;
    end else begin
      case (state_q)
        ST_DEV_ADDR, ST_REG_PTR, ST_WR_BYTE: begin
          if (scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = last_rx ? '0 : bit_cnt_q + 1'b1;
          end
          if (last_rx) begin
            if (state_q == ST_DEV_ADDR && !addr_hit) nack_d = sat_inc8(nack_q);
            if (state_q == ST_REG_PTR) ptr_d = byte_in[PTR_W-1:0];
            if (state_q == ST_WR_BYTE) begin
              wr_en_d   = 1'b1;
              wr_addr_d = ptr_q;
              wr_data_d = byte_in;
              ptr_d     = ptr_q + PTR_W'(1);
            end
          end
        end
        ST_ACK_ADDR, ST_ACK_PTR, ST_ACK_WR: begin
          if (scl_fall) sda_oe_d = ~sda_oe_q;
          if (ack_done && state_q == ST_ACK_ADDR && shift_q[0]) begin
            shift_d  = RD_DATA;
            sda_oe_d = ~RD_DATA[7];
            ptr_d    = ptr_q + PTR_W'(1);
          end
        end
        ST_RD_BYTE: begin
          if (scl_rise) bit_cnt_d = bit_cnt_q + 1'b1;
          if (scl_fall) begin
            if (bit_cnt_q == BYTE_DONE) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
            end else begin
              shift_d  = {shift_q[6:0], 1'b0};
              sda_oe_d = ~shift_q[6];
            end
          end
        end
        ST_RD_ACK: begin
          if (scl_rise && sda_f) nack_d = sat_inc8(nack_q);
          if (scl_fall) begin
            shift_d  = RD_DATA;
            sda_oe_d = ~RD_DATA[7];
            ptr_d    = ptr_q + PTR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLOCK_IN or negedge RST_N) begin
    if (!RST_N) begin
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      ptr_q     <= '0;
      nack_q    <= '0;
      shift_q   <= '0;
      bit_cnt_q <= '0;
    end else begin
      sda_oe_q  <= sda_oe_d;
      busy_q    <= busy_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      ptr_q     <= ptr_d;
      nack_q    <= nack_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign SDA_OE   = sda_oe_q;
  assign WR_EN    = wr_en_q;
  assign WR_ADDR  = wr_addr_q;
  assign WR_DATA  = wr_data_q;
  assign RD_ADDR  = ptr_q;
  assign BUSY     = busy_q;
  assign NACK_CNT = nack_q;

endmodule
